amount_display_decoder: RTL and testbench

- Takes the binary water amount (mL) produced by the keypad-entry block and converts it back into decimal digits for the board's 7-segment displays.
- A load pulse starts the conversion. A sequential double-dabble (shift-and-add-3) engine runs for one iteration per cycle.
- Registered BCD and segment outputs, plus a busy/done handshake, go to the display and dispensing control.

---
 rtl/amount_display_decoder.sv | 163 ++++++++++++++++
 tb/tb_amount_display_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/amount_display_decoder.sv
// Binary mL amount to BCD digits and active-low 7-segment codes (sequential double-dabble).
// Optional: define BLANK_LEADING_ZEROS_EN to blank zero digits above the most significant non-zero digit.
module amount_display_decoder #(
    parameter int DIGIT_COUNT = 4,
    parameter int VALUE_WIDTH = 14
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [VALUE_WIDTH-1:0]   value,
    input  logic                     load,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [4*DIGIT_COUNT-1:0] bcd,
    output logic [7*DIGIT_COUNT-1:0] segments
);

    localparam int unsigned DIGITS = DIGIT_COUNT;
    localparam int          BCD_W  = 4 * DIGIT_COUNT;
    localparam int          SEG_W  = 7 * DIGIT_COUNT;
    localparam int          CNT_W  = $clog2(VALUE_WIDTH + 1);

    localparam logic [VALUE_WIDTH-1:0] MAX_VALUE = VALUE_WIDTH'(10 ** DIGIT_COUNT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_UPDATE  = 2'd2;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [1:0]             state;
    logic [VALUE_WIDTH-1:0] shift_reg;
    logic [BCD_W-1:0]       scratch;
    logic [CNT_W-1:0]       counter;
    logic                   overflow_pending;

    logic [BCD_W-1:0]       scratch_adj;
    logic [BCD_W-1:0]       scratch_next;
    logic [VALUE_WIDTH-1:0] shift_next;
    logic [SEG_W-1:0]       result_seg;
    logic [3:0]             digit;
`ifdef BLANK_LEADING_ZEROS_EN
    logic                   leading;
`endif

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] reset_segment(input int unsigned idx);
`ifdef BLANK_LEADING_ZEROS_EN
        return (idx == 0) ? SEG_ZERO : SEG_BLANK;
`else
        return (idx == 0) ? SEG_ZERO : SEG_ZERO;
`endif
    endfunction

    // Add-3 correction on every nibble >= 5, then shift one binary bit into the BCD scratch.
    always_comb begin
        scratch_adj = scratch;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        {scratch_next, shift_next} = {scratch_adj, shift_reg} << 1;
    end

    // Walk digits from most significant down so leading zeros can be recognised in one pass.
    always_comb begin
        result_seg = '1;
        digit      = '0;
`ifdef BLANK_LEADING_ZEROS_EN
        leading    = 1'b1;
`endif
        for (int unsigned j = 0; j < DIGITS; j++) begin
            digit = scratch[4*(DIGITS-1-j) +: 4];
`ifdef BLANK_LEADING_ZEROS_EN
            if (leading && digit == 4'd0 && j != DIGITS - 1) begin
                result_seg[7*(DIGITS-1-j) +: 7] = SEG_BLANK;
            end else begin
                leading = 1'b0;
                result_seg[7*(DIGITS-1-j) +: 7] = seg_encode(digit);
            end
`else
            result_seg[7*(DIGITS-1-j) +: 7] = seg_encode(digit);
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            shift_reg        <= '0;
            scratch          <= '0;
            counter          <= '0;
            overflow_pending <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            overflow         <= 1'b0;
            bcd              <= '0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                segments[7*i +: 7] <= reset_segment(i);
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        shift_reg        <= value;
                        scratch          <= '0;
                        counter          <= CNT_W'(VALUE_WIDTH);
                        overflow_pending <= (value > MAX_VALUE);
                        busy             <= 1'b1;
                        state            <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    scratch   <= scratch_next;
                    shift_reg <= shift_next;
                    counter   <= counter - 1'b1;
                    if (counter == CNT_W'(1)) begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    overflow <= overflow_pending;
                    if (overflow_pending) begin
                        bcd      <= '1;
                        segments <= {DIGIT_COUNT{SEG_DASH}};
                    end else begin
                        bcd      <= scratch;
                        segments <= result_seg;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amount_display_decoder.sv
// Scoreboard bench for amount_display_decoder: stimulus pushes decimal-model results, a monitor checks every cycle.
module tb_amount_display_decoder;

    localparam int DC   = 4;
    localparam int VW   = 14;
    localparam int MAXV = 10 ** DC - 1;

    typedef struct {
        int                done_cyc;
        logic [4*DC-1:0]   bcd;
        logic [7*DC-1:0]   seg;
        logic              ovf;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [VW-1:0]     value = '0;
    logic              load  = 1'b0;
    logic              busy, done, overflow;
    logic [4*DC-1:0]   bcd;
    logic [7*DC-1:0]   segments;

    int   cyc         = 0;
    int   checks      = 0;
    int   errors      = 0;
    int   last_k      = -1000;
    int   next_accept = 0;
    exp_t q[$];
    exp_t cur;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    amount_display_decoder #(.DIGIT_COUNT(DC), .VALUE_WIDTH(VW)) dut (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd      (bcd),
        .segments (segments)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int v);
        exp_t e;
        int   d;
        int   top;
        e.done_cyc = 0;
        e.seg      = '0;
        top        = 0;
        if (v > MAXV) begin
            e.ovf = 1'b1;
            e.bcd = '1;
            for (int i = 0; i < DC; i++) e.seg[7*i +: 7] = 7'b0111111;
        end else begin
            e.ovf = 1'b0;
            e.bcd = '0;
            for (int i = 0; i < DC; i++) begin
                d = (v / (10 ** i)) % 10;
                e.bcd[4*i +: 4] = 4'(d);
                e.seg[7*i +: 7] = seg_tab[d];
                if (d != 0) top = i;
            end
`ifdef BLANK_LEADING_ZEROS_EN
            for (int i = 1; i < DC; i++) if (i > top) e.seg[7*i +: 7] = 7'b1111111;
`endif
        end
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e = model(0);
        e.done_cyc = 0;
        return e;
    endfunction

    // Monitor: done must appear exactly on the predicted cycle; outputs hold between results.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (q.size() > 0 && q[0].done_cyc == cyc) begin
                check("done_pulse", done, 1);
                cur = q.pop_front();
            end else begin
                check("done_idle", done, 0);
            end
            check("busy", busy, (cyc >= last_k && cyc <= last_k + VW) ? 1 : 0);
            check("bcd", bcd, cur.bcd);
            check("segments", segments, cur.seg);
            check("overflow", overflow, cur.ovf);
        end
    end

    task automatic goto_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    // Drive a one-cycle load from a negedge; the model decides whether the DUT accepts it.
    task automatic pulse(input int v);
        exp_t e;
        int   k;
        value = VW'(v);
        load  = 1'b1;
        k     = cyc + 1;
        if (k >= next_accept) begin
            e          = model(v);
            e.done_cyc = k + VW + 1;
            q.push_back(e);
            last_k      = k;
            next_accept = k + VW + 2;
        end
        @(negedge clock);
        load  = 1'b0;
        value = VW'($urandom);
    endtask

    task automatic check_reset_state();
        exp_t r;
        r = reset_exp();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_bcd", bcd, 0);
        check("rst_segments", segments, r.seg);
    endtask

    initial begin
        int k;
        int v;
        cur = reset_exp();
        repeat (3) @(negedge clock);
        check_reset_state();
        reset = 1'b1;
        repeat (3) @(negedge clock);

        pulse(1234);
        goto_cyc(last_k + VW + 1);
        pulse(9999);
        goto_cyc(last_k + VW + 1);
        pulse(0);
        goto_cyc(last_k + VW + 1);
        pulse(10000);
        goto_cyc(last_k + VW + 1);
        pulse(5);
        goto_cyc(last_k + VW + 2);

        pulse(777);
        k = last_k;
        goto_cyc(k + 2);
        pulse(42);
        goto_cyc(k + 14);
        pulse(42);
        pulse(42);
        goto_cyc(last_k + VW + 3);

        pulse(305);
        goto_cyc(last_k + VW + 3);
        pulse(16383);
        goto_cyc(last_k + VW + 3);

        pulse(8642);
        goto_cyc(last_k + 5);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state();
        q.delete();
        cur         = reset_exp();
        last_k      = -1000;
        next_accept = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 60; i++) begin
            v = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXV + 1, (1 << VW) - 1)
                                            : $urandom_range(0, MAXV);
            pulse(v);
            repeat ($urandom_range(0, 20)) @(negedge clock);
        end

        goto_cyc(((next_accept > cyc) ? next_accept : cyc) + 3);
        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
